// File: rtl/credential_entry_pkg.sv
// Constants and state encoding shared by the credential entry block and the unlocker.
package credential_entry_pkg;
  localparam int CHAR_W    = 5;
  localparam int NUM_CHARS = 4;
  localparam int MAX_COUNT = 2 * NUM_CHARS;
  localparam int CNT_W     = 4;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] USER  = 2'd1;
  localparam logic [1:0] PASS  = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  function automatic logic [1:0] state_of(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)                            return EMPTY;
    else if (cnt < CNT_W'(NUM_CHARS))         return USER;
    else if (cnt < CNT_W'(MAX_COUNT))         return PASS;
    else                                      return FULL;
  endfunction
endpackage

// File: rtl/credential_entry_if.sv
// Board-side controls plus the username/password bus presented to the unlocker.
interface credential_entry_if;
  import credential_entry_pkg::*;

  logic [CHAR_W-1:0] char_sel;
  logic              btn_enter;
  logic              btn_back;
  logic              resetCount;
  logic [CHAR_W-1:0] userNameInput0;
  logic [CHAR_W-1:0] userNameInput1;
  logic [CHAR_W-1:0] userNameInput2;
  logic [CHAR_W-1:0] userNameInput3;
  logic [CHAR_W-1:0] passwordInput0;
  logic [CHAR_W-1:0] passwordInput1;
  logic [CHAR_W-1:0] passwordInput2;
  logic [CHAR_W-1:0] passwordInput3;
  logic [CNT_W-1:0]  inputCount;
  logic              entry_full;
  logic              timeout_pulse;

  modport master (
    input  char_sel, btn_enter, btn_back, resetCount,
    output userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    output passwordInput0, passwordInput1, passwordInput2, passwordInput3,
    output inputCount, entry_full, timeout_pulse
  );

  modport slave (
    output char_sel, btn_enter, btn_back, resetCount,
    input  userNameInput0, userNameInput1, userNameInput2, userNameInput3,
    input  passwordInput0, passwordInput1, passwordInput2, passwordInput3,
    input  inputCount, entry_full, timeout_pulse
  );
endinterface

// File: rtl/credential_entry_rise_detect.sv
// Rising-edge detector: registered history, event visible in the cycle the new level is sampled.
module credential_entry_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic level_q;

  // History loads the live level under reset so a held input never fires on release of rst.
  always_ff @(posedge clk) begin
    if (rst) level_q <= level;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;
endmodule

// File: rtl/credential_entry.sv
// Collects username then password characters from switch + button entry for the unlocker.
module credential_entry
  import credential_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  credential_entry_if.master  bus
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int IW = $clog2(MAX_COUNT);

  logic enter_ev, back_ev, clr_ev;

  credential_entry_rise_detect u_enter (.clk(clk), .rst(rst), .level(bus.btn_enter),  .pulse(enter_ev));
  credential_entry_rise_detect u_back  (.clk(clk), .rst(rst), .level(bus.btn_back),   .pulse(back_ev));
  credential_entry_rise_detect u_clr   (.clk(clk), .rst(rst), .level(bus.resetCount), .pulse(clr_ev));

  logic [CHAR_W-1:0] slot_q [MAX_COUNT];
  logic [CHAR_W-1:0] slot_n [MAX_COUNT];
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [1:0]        state_q;
  logic [TW-1:0]     idle_q, idle_n;
  logic              full_q, to_q, to_n, wipe;
  logic [IW-1:0]     wr_idx, del_idx;

  assign wr_idx  = cnt_q[IW-1:0];
  assign del_idx = IW'(cnt_q - CNT_W'(1));

  // Priority: clear edge, then back, then enter; losing events in the same cycle are dropped.
  always_comb begin
    cnt_n  = cnt_q;
    slot_n = slot_q;
    idle_n = idle_q;
    to_n   = 1'b0;
    wipe   = 1'b0;
    if (clr_ev) begin
      wipe = 1'b1;
    end else if (back_ev) begin
      idle_n = '0;
      if (state_q != EMPTY) begin
        cnt_n           = cnt_q - CNT_W'(1);
        slot_n[del_idx] = '0;
      end
    end else if (enter_ev) begin
      idle_n = '0;
      if (state_q != FULL) begin
        cnt_n          = cnt_q + CNT_W'(1);
        slot_n[wr_idx] = bus.char_sel;
      end
    end else if (state_q == EMPTY) begin
      idle_n = '0;
    end else if (idle_q == T_LAST) begin
      wipe = 1'b1;
      to_n = 1'b1;
    end else begin
      idle_n = idle_q + TW'(1);
    end
    if (wipe) begin
      cnt_n  = '0;
      idle_n = '0;
      for (int i = 0; i < MAX_COUNT; i++) slot_n[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= EMPTY;
      idle_q  <= '0;
      full_q  <= 1'b0;
      to_q    <= 1'b0;
      for (int i = 0; i < MAX_COUNT; i++) slot_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_n;
      state_q <= state_of(cnt_n);
      idle_q  <= idle_n;
      full_q  <= (cnt_n == CNT_W'(MAX_COUNT));
      to_q    <= to_n;
      for (int i = 0; i < MAX_COUNT; i++) slot_q[i] <= slot_n[i];
    end
  end

  assign bus.userNameInput0 = slot_q[0];
  assign bus.userNameInput1 = slot_q[1];
  assign bus.userNameInput2 = slot_q[2];
  assign bus.userNameInput3 = slot_q[3];
  assign bus.passwordInput0 = slot_q[NUM_CHARS + 0];
  assign bus.passwordInput1 = slot_q[NUM_CHARS + 1];
  assign bus.passwordInput2 = slot_q[NUM_CHARS + 2];
  assign bus.passwordInput3 = slot_q[NUM_CHARS + 3];
  assign bus.inputCount     = cnt_q;
  assign bus.entry_full     = full_q;
  assign bus.timeout_pulse  = to_q;
endmodule
